// File: rtl/ahb_apb_bridge.sv
// ahb_apb_bridge: AHB-Lite slave turning single transfers into APB4 accesses,
// holding the AHB data phase with wait states and mapping faults to the ERROR response.
module ahb_apb_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int PADDR_WIDTH    = 16,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   hsel,
   input  logic [ADDR_WIDTH-1:0]  haddr,
   input  logic                   hwrite,
   input  logic [2:0]             hsize,
   input  logic [1:0]             htrans,
   input  logic [DATA_WIDTH-1:0]  hwdata,
   output logic [DATA_WIDTH-1:0]  hrdata,
   output logic                   hready,
   output logic                   hresp,
   output logic [PADDR_WIDTH-1:0] paddr,
   output logic                   psel,
   output logic                   penable,
   output logic                   pwrite,
   output logic [DATA_WIDTH-1:0]  pwdata,
   output logic [3:0]             pstrb,
   input  logic [DATA_WIDTH-1:0]  prdata,
   input  logic                   pready,
   input  logic                   pslverr
);
   localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2} state_t;
   state_t                 state, state_d;
   logic [1:0]             size, size_d;
   logic [CW-1:0]          cnt, cnt_d;
   logic [DATA_WIDTH-1:0]  hrdata_d, pwdata_d;
   logic [PADDR_WIDTH-1:0] paddr_d;
   logic [3:0]             pstrb_d;
   logic                   hready_d, hresp_d, psel_d, penable_d, pwrite_d;
   logic                   accept, illegal, timeout, done_ok, unused;
   assign accept  = hsel && htrans[1] && (state == IDLE || state == ERR2);
   assign illegal = hsize > 3'd2 || (hsize == 3'd2 && haddr[1:0] != 2'b00) || (hsize == 3'd1 && haddr[0]);
   assign timeout = TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES - 1);
   assign done_ok = pready && !pslverr;
   // Upper address bits are decoded by the interconnect into hsel.
   assign unused  = ^{haddr[ADDR_WIDTH-1:PADDR_WIDTH], htrans[0]};
   always_comb begin
      state_d   = state;
      size_d    = size;
      cnt_d     = cnt;
      hready_d  = hready;
      hresp_d   = hresp;
      hrdata_d  = hrdata;
      paddr_d   = paddr;
      psel_d    = psel;
      penable_d = penable;
      pwrite_d  = pwrite;
      pwdata_d  = pwdata;
      pstrb_d   = pstrb;
      case (state)
         IDLE, ERR2: begin
            state_d  = !accept ? IDLE : illegal ? ERR1 : WDATA;
            hready_d = !accept;
            hresp_d  = accept && illegal;
            if (accept && !illegal) begin
               paddr_d  = haddr[PADDR_WIDTH-1:0];
               pwrite_d = hwrite;
               size_d   = hsize[1:0];
            end
         end
         WDATA: begin
            state_d  = SETUP;
            psel_d   = 1'b1;
            pwdata_d = pwrite ? hwdata : pwdata;
            pstrb_d  = !pwrite ? 4'b0000 :
                       size == 2'd0 ? 4'b0001 << paddr[1:0] :
                       size == 2'd1 ? (paddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
            cnt_d     = '0;
         end
         ACCESS: begin
            cnt_d = cnt + CW'(1);
            if (pready || timeout) begin
               state_d   = done_ok ? IDLE : ERR1;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               hready_d  = done_ok;
               hresp_d   = !done_ok;
               hrdata_d  = done_ok && !pwrite ? prdata : hrdata;
            end
         end
         ERR1: begin
            state_d  = ERR2;
            hready_d = 1'b1;
            hresp_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         size    <= '0;
         cnt     <= '0;
         hready  <= 1'b1;
         hresp   <= 1'b0;
         hrdata  <= '0;
         paddr   <= '0;
         psel    <= 1'b0;
         penable <= 1'b0;
         pwrite  <= 1'b0;
         pwdata  <= '0;
         pstrb   <= '0;
      end else begin
         state   <= state_d;
         size    <= size_d;
         cnt     <= cnt_d;
         hready  <= hready_d;
         hresp   <= hresp_d;
         hrdata  <= hrdata_d;
         paddr   <= paddr_d;
         psel    <= psel_d;
         penable <= penable_d;
         pwrite  <= pwrite_d;
         pwdata  <= pwdata_d;
         pstrb   <= pstrb_d;
      end
   end
endmodule
